demux1to16_reg_loader: RTL and testbench

DEMUX1TO16_REG_LOADER -- requirements
Module: demux1to16_reg_loader

---
 rtl/demux1to16_reg_loader_pkg.sv | 19 +
 rtl/demux1to16_reg_loader_dec4to16.sv | 20 ++
 rtl/demux1to16_reg_loader.sv | 138 +++++++++++++
 tb/tb_demux1to16_reg_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux1to16_reg_loader_pkg.sv
// Shared types and sizing for the 1-to-16 register loader.
// Holds the FSM state encoding and slot geometry used by the top and decoder.
package demux1to16_reg_loader_pkg;

  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned SEL_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // True when the slot about to be written is the final one of a load.
  function automatic logic is_last_slot(input logic [SEL_W-1:0] sel);
    return sel == SEL_W'(NUM_SLOTS - 1);
  endfunction

endpackage

// File: rtl/demux1to16_reg_loader_dec4to16.sv
// 4-to-16 one-hot decoder producing per-slot write enables.
// All enables stay low unless the current word is being accepted.
module dec4to16
  import demux1to16_reg_loader_pkg::*;
(
  input  logic [SEL_W-1:0]     sel,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] we
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    we = '0;
    if (en) begin
      we[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1to16_reg_loader.sv
// Loads a stream of words into sixteen registered slots, out1 first, then
// presents them as a full set until the consumer acknowledges or a new load starts.
module demux1to16_reg_loader
  import demux1to16_reg_loader_pkg::*;
#(
  parameter int IWIDTH = 16,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_data,
  output logic [IWIDTH-1:0] out1,
  output logic [IWIDTH-1:0] out2,
  output logic [IWIDTH-1:0] out3,
  output logic [IWIDTH-1:0] out4,
  output logic [IWIDTH-1:0] out5,
  output logic [IWIDTH-1:0] out6,
  output logic [IWIDTH-1:0] out7,
  output logic [IWIDTH-1:0] out8,
  output logic [IWIDTH-1:0] out9,
  output logic [IWIDTH-1:0] out10,
  output logic [IWIDTH-1:0] out11,
  output logic [IWIDTH-1:0] out12,
  output logic [IWIDTH-1:0] out13,
  output logic [IWIDTH-1:0] out14,
  output logic [IWIDTH-1:0] out15,
  output logic [IWIDTH-1:0] out16,
  output logic [SEL_W-1:0]  wr_sel,
  output logic              out_valid,
  output logic              done,
  input  logic              out_ack
);

  // DWIDTH only mirrors the datapath parameter list; reject nonsense values.
  if (DWIDTH < 1 || IWIDTH < 1) begin : g_bad_width
    $error("demux1to16_reg_loader: IWIDTH and DWIDTH must be positive");
  end

  state_t                state_q;
  logic [IWIDTH-1:0]     slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  slot_we;
  logic                  accept;

  // NOTE: in_ready is decoded straight from the state register rather than
  // registered separately, so it can never disagree with the state.
  assign in_ready  = (state_q == ST_LOAD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_FULL);

  dec4to16 u_dec (
    .sel (wr_sel),
    .en  (accept),
    .we  (slot_we)
  );

  // NOTE: control state uses non-blocking assignments only, so every update in
  // this block sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_sel  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            wr_sel  <= '0;
          end
        end
        ST_LOAD: begin
          // A restart discards the count; a word accepted alongside it still lands.
          if (start) begin
            wr_sel <= '0;
          end else if (accept) begin
            if (is_last_slot(wr_sel)) begin
              state_q <= ST_FULL;
              wr_sel  <= '0;
              done    <= 1'b1;
            end else begin
              wr_sel <= wr_sel + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (start) begin
            state_q <= ST_LOAD;
            wr_sel  <= '0;
          end else if (out_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wr_sel  <= '0;
        end
      endcase
    end
  end

  // NOTE: the slots are sixteen discrete registers, not a RAM, so clearing them
  // on reset is cheap and gives a defined output value after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_we[i]) begin
          slot_q[i] <= in_data;
        end
      end
    end
  end

  assign out1  = slot_q[0];
  assign out2  = slot_q[1];
  assign out3  = slot_q[2];
  assign out4  = slot_q[3];
  assign out5  = slot_q[4];
  assign out6  = slot_q[5];
  assign out7  = slot_q[6];
  assign out8  = slot_q[7];
  assign out9  = slot_q[8];
  assign out10 = slot_q[9];
  assign out11 = slot_q[10];
  assign out12 = slot_q[11];
  assign out13 = slot_q[12];
  assign out14 = slot_q[13];
  assign out15 = slot_q[14];
  assign out16 = slot_q[15];

endmodule

// File: tb/tb_demux1to16_reg_loader.sv
// Self-checking bench for demux1to16_reg_loader: a constant vector table, directed
// corner-case sequences and randomized traffic against a word-count reference model.
module tb_demux1to16_reg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, out_ack;
  logic [15:0] in_data;
  logic        in_ready, out_valid, done;
  logic [3:0]  wr_sel;
  logic [15:0] o [16];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model: phase 0 idle, 1 loading, 2 full; count = words taken so far.
  int          m_phase;
  int          m_count;
  logic [15:0] m_slot [16];
  logic        m_done;

  always #5 clk = ~clk;

  demux1to16_reg_loader #(.IWIDTH(16), .DWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data),
    .out1(o[0]),   .out2(o[1]),   .out3(o[2]),   .out4(o[3]),
    .out5(o[4]),   .out6(o[5]),   .out7(o[6]),   .out8(o[7]),
    .out9(o[8]),   .out10(o[9]),  .out11(o[10]), .out12(o[11]),
    .out13(o[12]), .out14(o[13]), .out15(o[14]), .out16(o[15]),
    .wr_sel(wr_sel), .out_valid(out_valid), .done(done), .out_ack(out_ack)
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        ack;
    logic        exp_ready;
    logic        exp_valid;
    logic        exp_done;
    logic [3:0]  exp_sel;
    int          chk_idx;
    logic [15:0] chk_val;
  } vec_t;

  vec_t vec [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_count = 0;
    m_done  = 1'b0;
    for (int i = 0; i < 16; i++) m_slot[i] = '0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [15:0] d, input logic a);
    logic acc;
    acc    = (m_phase == 1) && v;
    m_done = 1'b0;
    if (acc) m_slot[m_count] = d;
    case (m_phase)
      0: if (s) begin m_phase = 1; m_count = 0; end
      1: begin
        if (s) m_count = 0;
        else if (acc) begin
          m_count++;
          if (m_count == 16) begin m_phase = 2; m_count = 0; m_done = 1'b1; end
        end
      end
      default: begin
        if (s) begin m_phase = 1; m_count = 0; end
        else if (a) m_phase = 0;
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, " in_ready"},  32'(in_ready),  32'(m_phase == 1));
    check({tag, " out_valid"}, 32'(out_valid), 32'(m_phase == 2));
    check({tag, " done"},      32'(done),      32'(m_done));
    check({tag, " wr_sel"},    32'(wr_sel),    32'(m_count % 16));
    for (int i = 0; i < 16; i++)
      check($sformatf("%s out%0d", tag, i + 1), 32'(o[i]), 32'(m_slot[i]));
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it.
  task automatic step(input string tag, input logic s, input logic v, input logic [15:0] d,
                      input logic a);
    start = s; in_valid = v; in_data = d; out_ack = a;
    @(posedge clk);
    model_edge(s, v, d, a);
    #1;
    if (done === 1'b1) done_cnt++;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = '0; out_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;

    // Hand-derived vectors starting from reset (IDLE, all slots zero).
    vec[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 0, 16'h0000};
    vec[1] = '{1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 0, 16'h1111};
    vec[2] = '{1'b0, 1'b0, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1, 16'h0000};
    vec[3] = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1, 16'h2222};
    vec[4] = '{1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2, 16'h3333};
    vec[5] = '{1'b0, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 0, 16'h4444};
    vec[6] = '{1'b0, 1'b0, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1, 16'h2222};

    do_reset();
    compare_all("reset");

    for (int i = 0; i < 7; i++) begin
      start = vec[i].start; in_valid = vec[i].valid; in_data = vec[i].data; out_ack = vec[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vec[i].exp_ready));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vec[i].exp_valid));
      check($sformatf("vec%0d done", i),      32'(done),      32'(vec[i].exp_done));
      check($sformatf("vec%0d wr_sel", i),    32'(wr_sel),    32'(vec[i].exp_sel));
      check($sformatf("vec%0d slot", i),      32'(o[vec[i].chk_idx]), 32'(vec[i].chk_val));
    end

    // Back-to-back load of 1..16.
    do_reset();
    step("b2b start", 1'b1, 1'b0, 16'h0, 1'b0);
    base = done_cnt;
    for (int i = 0; i < 16; i++) step("b2b word", 1'b0, 1'b1, 16'(i + 1), 1'b0);
    check("b2b done pulse", 32'(done), 32'd1);
    check("b2b out1", 32'(o[0]), 32'h0001);
    check("b2b out16", 32'(o[15]), 32'h0010);
    step("b2b hold", 1'b0, 1'b0, 16'h0, 1'b0);
    check("b2b done once", 32'(done_cnt - base), 32'd1);

    // Writes in FULL are ignored; out_ack returns to IDLE.
    step("full write", 1'b0, 1'b1, 16'hFFFF, 1'b0);
    check("full in_ready", 32'(in_ready), 32'd0);
    step("full ack", 1'b0, 1'b0, 16'h0, 1'b1);
    check("ack out_valid", 32'(out_valid), 32'd0);
    check("ack out16 kept", 32'(o[15]), 32'h0010);

    // Alternating in_valid: 32 cycles to complete.
    step("tog start", 1'b1, 1'b0, 16'h0, 1'b0);
    base = done_cnt;
    for (int i = 0; i < 32; i++)
      step("tog", 1'b0, (i % 2) == 0, (i % 2) == 0 ? 16'(i / 2 + 1) : 16'hDEAD, 1'b0);
    check("tog done count", 32'(done_cnt - base), 32'd1);
    check("tog out_valid", 32'(out_valid), 32'd1);
    check("tog out9", 32'(o[8]), 32'h0009);

    // Restart in LOAD after 5 words with a word accepted in the same cycle.
    step("rs start", 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) step("rs word", 1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
    step("rs restart", 1'b1, 1'b1, 16'hAAAA, 1'b0);
    check("rs out6", 32'(o[5]), 32'hAAAA);
    check("rs wr_sel", 32'(wr_sel), 32'd0);
    base = done_cnt;
    step("rs first", 1'b0, 1'b1, 16'hBBBB, 1'b0);
    check("rs out1", 32'(o[0]), 32'hBBBB);
    for (int i = 0; i < 14; i++) step("rs more", 1'b0, 1'b1, 16'(16'hC000 + i), 1'b0);
    check("rs no early done", 32'(done_cnt - base), 32'd0);
    step("rs last", 1'b0, 1'b1, 16'hCFFF, 1'b0);
    check("rs done", 32'(done_cnt - base), 32'd1);

    // start and out_ack together in FULL: start wins.
    step("full start+ack", 1'b1, 1'b0, 16'h0, 1'b1);
    check("sa out_valid", 32'(out_valid), 32'd0);
    check("sa in_ready", 32'(in_ready), 32'd1);
    check("sa wr_sel", 32'(wr_sel), 32'd0);

    // Asynchronous reset mid-load after 8 words.
    for (int i = 0; i < 8; i++) step("ar word", 1'b0, 1'b1, 16'(16'h7000 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
    #1;
    model_reset();
    check("ar out1", 32'(o[0]), 32'd0);
    check("ar out8", 32'(o[7]), 32'd0);
    check("ar wr_sel", 32'(wr_sel), 32'd0);
    check("ar in_ready", 32'(in_ready), 32'd0);
    check("ar out_valid", 32'(out_valid), 32'd0);
    check("ar done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar start", 1'b1, 1'b0, 16'h0, 1'b0);
    step("ar first", 1'b0, 1'b1, 16'h5A5A, 1'b0);
    check("ar first out1", 32'(o[0]), 32'h5A5A);
    check("ar first out2", 32'(o[1]), 32'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic s, v, a;
      s = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0);
      step("rnd", s, v, 16'($urandom), a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
